// File: rtl/disp_arbiter.sv
// disp_arbiter
// Time-shares one 8-digit seven-segment display driver among three 32-bit
// sources. Every posted value is latched into a per-source buffer and marked
// pending. The display is granted to one source at a time for at least HOLD+1
// cycles, then rotates round-robin to the next source with a pending value.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   req_valid  per-source one-cycle write strobe (bit i = source i)
//   req_data   source i value on [32*i+31:32*i], sampled when req_valid[i]=1
//   disp_data  registered value for the display driver
//   disp_en    registered one-cycle load strobe for the display driver
//   owner      current grant holder 0..2, 2'd3 = no owner yet
//   pend       per-source "unshown value waiting" flags
module disp_arbiter #(
  parameter logic [31:0] HOLD = 32'd49_999_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [95:0] req_data,
  output logic [31:0] disp_data,
  output logic        disp_en,
  output logic [1:0]  owner,
  output logic [2:0]  pend
);

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] buf0;
  logic [31:0] buf1;
  logic [31:0] buf2;
  logic [31:0] cnt;

  // load decision produced by the output logic
  logic        load;
  logic [1:0]  sel;
  logic [1:0]  s1;
  logic [1:0]  s2;

  // next source in round-robin order (mod 3)
  function automatic logic [1:0] next_src(input logic [1:0] s);
    case (s)
      2'd0:    next_src = 2'd1;
      2'd1:    next_src = 2'd2;
      default: next_src = 2'd0;
    endcase
  endfunction

  // pend bit of source s; out-of-range index reads as not pending
  function automatic logic is_pend(input logic [2:0] p, input logic [1:0] s);
    case (s)
      2'd0:    is_pend = p[0];
      2'd1:    is_pend = p[1];
      2'd2:    is_pend = p[2];
      default: is_pend = 1'b0;
    endcase
  endfunction

  // one-hot mask for source s
  function automatic logic [2:0] onehot(input logic [1:0] s);
    case (s)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // buffer contents of source s
  function automatic logic [31:0] buf_of(input logic [1:0] s, input logic [31:0] b0,
                                         input logic [31:0] b1, input logic [31:0] b2);
    case (s)
      2'd0:    buf_of = b0;
      2'd1:    buf_of = b1;
      default: buf_of = b2;
    endcase
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state: leave IDLE on the first pending value, never return except by reset
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pend != 3'b000) begin
          state_nxt = SHOW;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHOW:    state_nxt = SHOW;
      default: state_nxt = IDLE;
    endcase
  end

  // grant decision: which source (if any) is loaded into the display this cycle
  always_comb begin
    load = 1'b0;
    sel  = owner;
    s1   = next_src(owner);
    s2   = next_src(next_src(owner));
    case (state)
      IDLE: begin
        if (pend[0]) begin
          load = 1'b1;
          sel  = 2'd0;
        end else if (pend[1]) begin
          load = 1'b1;
          sel  = 2'd1;
        end else if (pend[2]) begin
          load = 1'b1;
          sel  = 2'd2;
        end else begin
          load = 1'b0;
        end
      end
      SHOW: begin
        if (cnt == HOLD) begin
          // a waiting non-owner takes priority over refreshing the owner
          if (is_pend(pend, s1)) begin
            load = 1'b1;
            sel  = s1;
          end else if (is_pend(pend, s2)) begin
            load = 1'b1;
            sel  = s2;
          end else if (is_pend(pend, owner)) begin
            load = 1'b1;
          end else begin
            load = 1'b0;
          end
        end else if (is_pend(pend, owner)) begin
          load = 1'b1;
        end else begin
          load = 1'b0;
        end
      end
      default: load = 1'b0;
    endcase
  end

  // datapath: buffers, pend flags, hold counter and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      buf0      <= 32'd0;
      buf1      <= 32'd0;
      buf2      <= 32'd0;
      pend      <= 3'b000;
      cnt       <= 32'd0;
      owner     <= 2'd3;
      disp_data <= 32'd0;
      disp_en   <= 1'b0;
    end else begin
      if (req_valid[0]) buf0 <= req_data[31:0];
      else              buf0 <= buf0;
      if (req_valid[1]) buf1 <= req_data[63:32];
      else              buf1 <= buf1;
      if (req_valid[2]) buf2 <= req_data[95:64];
      else              buf2 <= buf2;

      // set wins over clear on the same edge
      pend    <= (pend & ~(load ? onehot(sel) : 3'b000)) | req_valid;
      disp_en <= load;

      if (load) begin
        disp_data <= buf_of(sel, buf0, buf1, buf2);
        owner     <= sel;
      end else begin
        disp_data <= disp_data;
        owner     <= owner;
      end

      // counter restarts on a new grant only; a refresh keeps it running
      if (load && (state == IDLE || sel != owner)) begin
        cnt <= 32'd0;
      end else if (state == SHOW && cnt < HOLD) begin
        cnt <= cnt + 32'd1;
      end else begin
        cnt <= cnt;
      end
    end
  end

endmodule
